keccak_stream_driver: RTL and testbench
=======================================

# keccak_stream_driver

Front-end adapter for the `keccak` hash core.
- Accepts a message as a 32-bit streaming packet and serializes it into the core's byte interface (`in`/`in_ready`/`is_last`), honouring `buffer_full`.
- Captures the 512-bit digest when the core raises `out_ready` and returns it as a 16-word streaming packet.
- Reset-cycles the core between messages.
- Sits between the system stream fabric and one `keccak` instance.

## Interface
Parameters: none (widths fixed by the core).

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `snk_data` in 32: message bytes, `[31:24]` first.
- `snk_valid` in 1: sink word valid.
- `snk_ready` out 1: sink can accept a word.
- `snk_sop` in 1: first word of message.
- `snk_eop` in 1: last word of message.
- `snk_empty` in 2: unused low-order bytes in the eop word (0–3).
- `src_data` out 32: digest word; word 0 = digest `[511:480]`.
- `src_valid` out 1: source word valid.
- `src_ready` in 1: downstream accepts the word.
- `src_sop` out 1: high with word 0.
- `src_eop` out 1: high with word 15.
- `k_reset` out 1: synchronous reset to the core.
- `k_in` out 8: byte to the core.
- `k_in_ready` out 1: `k_in` valid.
- `k_is_last` out 1: `k_in` is the final message byte.
- `k_buffer_full` in 1: core cannot take a byte this cycle.
- `k_out` in 512: core digest.
- `k_out_ready` in 1: digest valid; stays high until `k_reset`.

## Operation
- **Handshakes**
  - Sink transfer: `snk_valid & snk_ready`.
  - Core byte transfer: `k_in_ready & !k_buffer_full`.
  - Source transfer: `src_valid & src_ready`.
- **State machine:** IDLE, FEED, WAIT, OUT, FLUSH.
- **IDLE**
  - `snk_ready`=1.
  - A word without `snk_sop` is accepted and discarded.
  - A word with `snk_sop` is loaded into the 32-bit hold register → FEED.
- **Hold register**
  - Bytes valid = 4 − `snk_empty` if `snk_eop`, else 4.
  - An `snk_empty` value on a non-eop word is ignored.
  - A 2-bit byte index walks `[31:24]`, `[23:16]`, …
- **FEED**
  - Drive `k_in` = current byte and `k_in_ready`=1 while the hold register is non-empty.
  - Advance the byte index only on a core byte transfer.
  - `k_is_last`=1 only with the final valid byte of the eop word.
  - `snk_ready` = hold empty and eop not yet seen. It is registered-state derived, with no combinational path from `snk_valid`.
  - A `snk_sop` seen in FEED is ignored; the word is treated as ordinary data.
  - After the `k_is_last` byte transfers → WAIT.
- **WAIT**
  - `snk_ready`=0.
  - On `k_out_ready`=1: latch `k_out` into the digest register, word counter=0 → OUT.
- **OUT**
  - `src_valid`=1 and `src_data` = digest word[counter].
  - `src_sop` = (counter==0); `src_eop` = (counter==15).
  - Advance on each source transfer.
  - After word 15 transfers → FLUSH.
- **FLUSH**
  - `k_reset`=1 for exactly one cycle → IDLE.
  - Clears the core's `state`/`out_ready` before the next message.
- **Byte-count limit:** messages of 1 to unbounded bytes. A zero-byte message is not representable and is not supported.

## Timing
- **Reset values**
  - State = IDLE; `snk_ready`=0 during reset.
  - `k_reset`=1, `k_in`=0, `k_in_ready`=0, `k_is_last`=0.
  - `src_valid`=0, `src_sop`=0, `src_eop`=0, `src_data`=0.
- **Out of reset**
  - `k_reset` deasserts on the first `clk` edge after `reset` falls.
  - `snk_ready` rises on that same edge.
- **Feed latency:** first core byte is presented the cycle after the sop transfer.
- **Throughput:** 4 bytes per 5 cycles with no backpressure, since the next word is accepted the cycle after the hold register empties.
- **Core backpressure:** `k_buffer_full`=1 holds `k_in`/`k_is_last` stable, with no byte skipped or repeated.
- **Digest output**
  - Digest word 0 is presented the cycle after `k_out_ready` is sampled high in WAIT.
  - `src_data`/`src_sop`/`src_eop` are held stable while `src_valid & !src_ready`.
- **Core reset window:** `k_reset` pulses the cycle after the word-15 transfer; `snk_ready`=1 the following cycle.
- **Reset mid-operation:** any state returns to IDLE asynchronously. The partial message, digest and counters are discarded, and `k_reset` is asserted.

## Test plan
- **"abc":** single word `0x61626300`, sop=eop=1, empty=1, no backpressure.
  - Core sees bytes 61, 62, 63 with `k_is_last` only on 63.
  - Source emits 16 words matching the Keccak-512 model; word 0 = `0x18587dc2`, `src_sop` on word 0, `src_eop` on word 15.
  - One-cycle `k_reset` follows.
- **Core backpressure:** 8-byte message `0x00010203`, `0x04050607` (empty=0), `k_buffer_full` toggled every other cycle.
  - Core byte stream is exactly 00..07, `k_is_last` on 07, with no duplicates.
- **Empty-field sweep:** eop word with empty = 0, 1, 2, 3 → 4, 3, 2, 1 bytes delivered; last byte flagged with `k_is_last`.
- **Source backpressure:** `src_ready` low for 3 cycles on words 0, 7 and 15.
  - Data is held stable; exactly 16 transfers occur; FLUSH happens only after word 15.
- **Framing errors:** stray non-sop words in IDLE are dropped; a sop inside FEED is hashed as data.
  - Two back-to-back "abc" messages yield identical digests.
- **Reset mid-FEED:** reset after 2 bytes → outputs at reset values; a following "abc" still yields word 0 = `0x18587dc2`.

Source files
------------

// File: rtl/keccak_stream_driver.sv
// Stream front-end for one keccak core: serializes a 32-bit sink packet into core bytes,
// returns the 512-bit digest as a 16-word source packet, then reset-cycles the core.
module keccak_stream_driver (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  snk_data,
  input  logic         snk_valid,
  output logic         snk_ready,
  input  logic         snk_sop,
  input  logic         snk_eop,
  input  logic [1:0]   snk_empty,
  output logic [31:0]  src_data,
  output logic         src_valid,
  input  logic         src_ready,
  output logic         src_sop,
  output logic         src_eop,
  output logic         k_reset,
  output logic [7:0]   k_in,
  output logic         k_in_ready,
  output logic         k_is_last,
  input  logic         k_buffer_full,
  input  logic [511:0] k_out,
  input  logic         k_out_ready
);

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned DIG_W   = 512;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned WCNT_W  = 4;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(15);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_OUT,
    S_FLUSH
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [WORD_W-1:0]   r_hold;
  logic [CNT_W-1:0]    r_left;
  logic                r_eop_seen;
  logic [DIG_W-1:0]    r_digest;
  logic [WCNT_W-1:0]   r_wcnt;
  logic                r_rst_hold;

  logic                w_hold_full;
  logic                w_snk_xfer;
  logic                w_k_xfer;
  logic                w_src_xfer;
  logic [CNT_W-1:0]    w_nbytes;

  // All handshake outputs decode registered state only; no input-to-output paths.
  assign w_hold_full = (r_left != '0);
  assign snk_ready   = !r_rst_hold &&
                       ((r_state == S_IDLE) ||
                        (r_state == S_FEED && !w_hold_full && !r_eop_seen));
  assign k_in_ready  = (r_state == S_FEED) && w_hold_full;
  assign k_in        = k_in_ready ? r_hold[WORD_W-1 -: BYTE_W] : '0;
  assign k_is_last   = k_in_ready && r_eop_seen && (r_left == CNT_W'(1));
  assign k_reset     = r_rst_hold || (r_state == S_FLUSH);
  assign src_valid   = (r_state == S_OUT);
  assign src_data    = src_valid ? r_digest[DIG_W-1 -: WORD_W] : '0;
  assign src_sop     = src_valid && (r_wcnt == '0);
  assign src_eop     = src_valid && (r_wcnt == LAST_WORD);

  assign w_snk_xfer  = snk_valid && snk_ready;
  assign w_k_xfer    = k_in_ready && !k_buffer_full;
  assign w_src_xfer  = src_valid && src_ready;
  assign w_nbytes    = snk_eop ? CNT_W'(CNT_W'(4) - {1'b0, snk_empty}) : CNT_W'(4);

  // Holds the core in reset until the first clock edge after reset falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rst_hold <= 1'b1;
    else       r_rst_hold <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_snk_xfer && snk_sop)   w_next = S_FEED;
      S_FEED:  if (w_k_xfer && k_is_last)   w_next = S_WAIT;
      S_WAIT:  if (k_out_ready)             w_next = S_OUT;
      S_OUT:   if (w_src_xfer && src_eop)   w_next = S_FLUSH;
      S_FLUSH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Hold register shifts out MSB-first; digest register shifts out word 0 first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold     <= '0;
      r_left     <= '0;
      r_eop_seen <= 1'b0;
      r_digest   <= '0;
      r_wcnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_snk_xfer && snk_sop) begin
            r_hold     <= snk_data;
            r_left     <= w_nbytes;
            r_eop_seen <= snk_eop;
          end
        end
        S_FEED: begin
          if (w_k_xfer) begin
            r_hold <= {r_hold[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
            r_left <= r_left - CNT_W'(1);
          end else if (w_snk_xfer) begin
            r_hold     <= snk_data;
            r_left     <= w_nbytes;
            r_eop_seen <= snk_eop;
          end
        end
        S_WAIT: begin
          if (k_out_ready) begin
            r_digest <= k_out;
            r_wcnt   <= '0;
          end
        end
        S_OUT: begin
          if (w_src_xfer) begin
            r_digest <= {r_digest[DIG_W-WORD_W-1:0], WORD_W'(0)};
            r_wcnt   <= r_wcnt + WCNT_W'(1);
          end
        end
        S_FLUSH: begin
          r_eop_seen <= 1'b0;
          r_left     <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_stream_driver.sv
// Bench for keccak_stream_driver with a behavioural core and a digest-word scoreboard.
module tb_keccak_stream_driver;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  localparam logic [511:0] ABC_DIGEST =
    512'h18587dc2ea106b9a1563e32b3312421ca164c7f1f07bc922a9c83d77cea3a1e5d0c69910739025372dc14ac9642629379540c17e2a65b19d77aa511a9d00bb96;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  snk_data = '0;
  logic         snk_valid = 1'b0;
  logic         snk_ready;
  logic         snk_sop = 1'b0;
  logic         snk_eop = 1'b0;
  logic [1:0]   snk_empty = '0;
  logic [31:0]  src_data;
  logic         src_valid;
  logic         src_ready = 1'b1;
  logic         src_sop;
  logic         src_eop;
  logic         k_reset;
  logic [7:0]   k_in;
  logic         k_in_ready;
  logic         k_is_last;
  logic         k_buffer_full = 1'b0;
  logic [511:0] k_out = '0;
  logic         k_out_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  exp_bytes[$];
  logic [7:0]  core_log[$];
  bit          core_last[$];
  logic [31:0] out_log[$];

  bit   bp_mode   = 1'b0;
  bit   src_bp_en = 1'b0;
  int   bp_idx    = -1;
  int   stall_cnt = 0;
  int   out_idx   = 0;
  int   flush_ph  = 0;
  bit   held_v    = 1'b0;
  logic [31:0] held_d;
  logic held_s, held_e;
  logic [7:0] cur_msg[$];
  int   cd = 0;

  keccak_stream_driver dut (
    .clk(clk), .reset(reset),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .snk_sop(snk_sop), .snk_eop(snk_eop), .snk_empty(snk_empty),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_sop(src_sop), .src_eop(src_eop),
    .k_reset(k_reset), .k_in(k_in), .k_in_ready(k_in_ready), .k_is_last(k_is_last),
    .k_buffer_full(k_buffer_full), .k_out(k_out), .k_out_ready(k_out_ready)
  );

  always #5 clk = ~clk;

  // Stand-in digest: the real Keccak-512 result for "abc", a mixing hash otherwise.
  function automatic logic [511:0] model_digest(input bq_t m);
    logic [511:0] d;
    logic [31:0]  h;
    if (m.size() == 3 && m[0] == 8'h61 && m[1] == 8'h62 && m[2] == 8'h63) return ABC_DIGEST;
    h = 32'h811c9dc5;
    foreach (m[i]) h = (h ^ {24'h0, m[i]}) * 32'h01000193;
    d = '0;
    for (int i = 0; i < 16; i++) begin
      h = (h ^ 32'(i)) * 32'h01000193;
      d[511-32*i -: 32] = h;
    end
    return d;
  endfunction

  // Behavioural core: logs bytes, raises out_ready a few cycles after the last byte.
  always @(negedge clk) begin
    if (k_reset) begin
      cur_msg.delete();
      cd = 0;
      k_out_ready = 1'b0;
      k_out = '0;
    end else if (k_in_ready && !k_buffer_full) begin
      cur_msg.push_back(k_in);
      core_log.push_back(k_in);
      core_last.push_back(k_is_last);
      if (k_is_last) cd = 3;
    end else if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        k_out = model_digest(cur_msg);
        k_out_ready = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    k_buffer_full = bp_mode ? ~k_buffer_full : 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (out_idx != bp_idx) begin
      bp_idx = out_idx;
      stall_cnt = 0;
    end
    if (src_bp_en && src_valid && (out_idx == 0 || out_idx == 7 || out_idx == 15) && stall_cnt < 3) begin
      src_ready = 1'b0;
      stall_cnt++;
    end else begin
      src_ready = 1'b1;
    end
  end

  // Scoreboard pop side plus hold-stability and core-reset-window checks.
  always @(negedge clk) begin
    if (!reset) begin
      if (held_v) begin
        n_checks++;
        if (src_valid !== 1'b1 || src_data !== held_d || src_sop !== held_s || src_eop !== held_e)
          $display("FAIL src_hold: got v=%b d=%h sop=%b eop=%b want v=1 d=%h sop=%b eop=%b",
                   src_valid, src_data, src_sop, src_eop, held_d, held_s, held_e);
        else n_pass++;
      end
      held_v = src_valid && !src_ready;
      held_d = src_data; held_s = src_sop; held_e = src_eop;
      if (flush_ph == 1) begin
        n_checks++;
        if (k_reset !== 1'b1) $display("FAIL flush_pulse: k_reset=%b want 1", k_reset);
        else n_pass++;
        flush_ph = 2;
      end else if (flush_ph == 2) begin
        n_checks++;
        if (k_reset !== 1'b0 || snk_ready !== 1'b1)
          $display("FAIL flush_end: k_reset=%b snk_ready=%b want 0 1", k_reset, snk_ready);
        else n_pass++;
        flush_ph = 0;
      end
      if (src_valid && src_ready) begin
        out_log.push_back(src_data);
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL src_unexpected: got %h want no word", src_data);
        else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (src_data !== e) $display("FAIL src_word%0d: got %h want %h", out_idx, src_data, e);
          else n_pass++;
        end
        n_checks++;
        if (src_sop !== (out_idx == 0) || src_eop !== (out_idx == 15))
          $display("FAIL src_frame%0d: sop=%b eop=%b want %b %b", out_idx, src_sop, src_eop,
                   out_idx == 0, out_idx == 15);
        else n_pass++;
        if (out_idx == 15) begin out_idx = 0; flush_ph = 1; end
        else out_idx++;
      end
    end
  end

  task automatic push_word(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em);
    int t = 0;
    snk_data = d; snk_sop = s; snk_eop = e; snk_empty = em; snk_valid = 1'b1;
    while (snk_ready !== 1'b1 && t < 500) begin @(posedge clk); #1; t++; end
    if (t >= 500) begin n_checks++; $display("FAIL sink_accept: snk_ready=%b want 1 within 500 cycles", snk_ready); end
    @(posedge clk); #1;
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0; snk_data = '0; snk_empty = '0;
  endtask

  task automatic send_msg(input wq_t w, input logic [1:0] em, input bit sop_dup);
    bq_t m;
    logic [511:0] d;
    foreach (w[i]) begin
      int nb;
      nb = (i == w.size() - 1) ? 4 - int'(em) : 4;
      for (int b = 0; b < nb; b++) m.push_back(w[i][31-8*b -: 8]);
    end
    d = model_digest(m);
    for (int i = 0; i < 16; i++) exp_q.push_back(d[511-32*i -: 32]);
    exp_bytes = m;
    foreach (w[i])
      push_word(w[i], (i == 0) || (sop_dup && i == 1), i == w.size() - 1,
                (i == w.size() - 1) ? em : 2'd3);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || flush_ph != 0) && t < 3000) begin @(posedge clk); #1; t++; end
    if (t >= 3000) begin
      n_checks++;
      $display("FAIL %s_timeout: %0d words outstanding want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({snk_ready, k_reset, k_in, k_in_ready, k_is_last, src_valid, src_sop, src_eop} !== {1'b0, 1'b1, 8'h00, 5'b0})
      $display("FAIL reset_ctrl: rdy=%b krst=%b kin=%h kir=%b kl=%b sv=%b ss=%b se=%b want 0 1 00 0 0 0 0 0",
               snk_ready, k_reset, k_in, k_in_ready, k_is_last, src_valid, src_sop, src_eop);
    else n_pass++;
    n_checks++;
    if (src_data !== 32'h0) $display("FAIL reset_data: got %h want 0", src_data);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_checks++;
    if (k_reset !== 1'b1 || snk_ready !== 1'b0)
      $display("FAIL reset_release_pre: k_reset=%b snk_ready=%b want 1 0", k_reset, snk_ready);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (k_reset !== 1'b0 || snk_ready !== 1'b1)
      $display("FAIL reset_release_edge: k_reset=%b snk_ready=%b want 0 1", k_reset, snk_ready);
    else n_pass++;
  endtask

  task automatic test_abc();
    wq_t w;
    w = {32'h61626300};
    core_log.delete(); core_last.delete(); out_log.delete();
    send_msg(w, 2'd1, 1'b0);
    n_checks++;
    if (k_in_ready !== 1'b1 || k_in !== 8'h61)
      $display("FAIL abc_latency: k_in_ready=%b k_in=%h want 1 61", k_in_ready, k_in);
    else n_pass++;
    wait_done("abc");
    n_checks++;
    if (core_log.size() != 3) $display("FAIL abc_bytes_n: got %0d want 3", core_log.size());
    else n_pass++;
    foreach (exp_bytes[i]) if (i < core_log.size()) begin
      n_checks++;
      if (core_log[i] !== exp_bytes[i] || core_last[i] !== (i == exp_bytes.size() - 1))
        $display("FAIL abc_byte%0d: got %h last=%b want %h last=%b", i, core_log[i], core_last[i],
                 exp_bytes[i], i == exp_bytes.size() - 1);
      else n_pass++;
    end
    n_checks++;
    if (out_log.size() != 16 || out_log[0] !== 32'h18587dc2)
      $display("FAIL abc_word0: got n=%0d w0=%h want 16 18587dc2", out_log.size(),
               out_log.size() > 0 ? out_log[0] : 32'h0);
    else n_pass++;
  endtask

  task automatic test_core_backpressure();
    wq_t w;
    w = {32'h00010203, 32'h04050607};
    core_log.delete(); core_last.delete();
    bp_mode = 1'b1;
    send_msg(w, 2'd0, 1'b0);
    wait_done("core_bp");
    bp_mode = 1'b0;
    n_checks++;
    if (core_log.size() != 8) $display("FAIL core_bp_n: got %0d want 8", core_log.size());
    else n_pass++;
    foreach (exp_bytes[i]) if (i < core_log.size()) begin
      n_checks++;
      if (core_log[i] !== 8'(i) || core_last[i] !== (i == 7))
        $display("FAIL core_bp_byte%0d: got %h last=%b want %h last=%b", i, core_log[i], core_last[i], 8'(i), i == 7);
      else n_pass++;
    end
  endtask

  task automatic test_empty_sweep();
    for (int e = 0; e < 4; e++) begin
      wq_t w;
      w = {32'hA1B2C3D4 ^ 32'(e)};
      core_log.delete(); core_last.delete();
      send_msg(w, 2'(e), 1'b0);
      wait_done("empty_sweep");
      n_checks++;
      if (core_log.size() != 4 - e) $display("FAIL empty%0d_n: got %0d want %0d", e, core_log.size(), 4 - e);
      else n_pass++;
      foreach (exp_bytes[i]) if (i < core_log.size()) begin
        n_checks++;
        if (core_log[i] !== exp_bytes[i] || core_last[i] !== (i == 3 - e))
          $display("FAIL empty%0d_byte%0d: got %h last=%b want %h last=%b", e, i, core_log[i], core_last[i],
                   exp_bytes[i], i == 3 - e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_src_backpressure();
    wq_t w;
    w = {32'h11223344, 32'h55000000};
    out_log.delete();
    bp_idx = -1;
    src_bp_en = 1'b1;
    send_msg(w, 2'd3, 1'b0);
    wait_done("src_bp");
    src_bp_en = 1'b0;
    n_checks++;
    if (out_log.size() != 16) $display("FAIL src_bp_count: got %0d want 16", out_log.size());
    else n_pass++;
  endtask

  task automatic test_framing();
    wq_t w;
    core_log.delete(); core_last.delete();
    push_word(32'hdeadbeef, 1'b0, 1'b0, 2'd0);
    push_word(32'h12345678, 1'b0, 1'b1, 2'd0);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (core_log.size() != 0) $display("FAIL stray_dropped: got %0d bytes want 0", core_log.size());
    else n_pass++;
    w = {32'h61626364, 32'h65660000};
    send_msg(w, 2'd2, 1'b1);
    wait_done("sop_in_feed");
    n_checks++;
    if (core_log.size() != 6) $display("FAIL sop_in_feed_n: got %0d want 6", core_log.size());
    else n_pass++;
    foreach (exp_bytes[i]) if (i < core_log.size()) begin
      n_checks++;
      if (core_log[i] !== exp_bytes[i] || core_last[i] !== (i == 5))
        $display("FAIL sop_in_feed_byte%0d: got %h last=%b want %h last=%b", i, core_log[i], core_last[i],
                 exp_bytes[i], i == 5);
      else n_pass++;
    end
    out_log.delete();
    w = {32'h61626300};
    send_msg(w, 2'd1, 1'b0);
    wait_done("b2b_first");
    send_msg(w, 2'd1, 1'b0);
    wait_done("b2b_second");
    n_checks++;
    if (out_log.size() != 32) $display("FAIL b2b_count: got %0d want 32", out_log.size());
    else begin
      bit same = 1'b1;
      for (int i = 0; i < 16; i++) if (out_log[i] !== out_log[i+16]) same = 1'b0;
      if (!same || out_log[16] !== 32'h18587dc2)
        $display("FAIL b2b_digest: second w0=%h same=%b want 18587dc2 1", out_log[16], same);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_feed();
    wq_t w;
    int t = 0;
    core_log.delete(); core_last.delete();
    push_word(32'h61626364, 1'b1, 1'b0, 2'd0);
    while (core_log.size() < 2 && t < 100) begin @(posedge clk); #1; t++; end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({snk_ready, k_reset, k_in, k_in_ready, k_is_last, src_valid, src_sop, src_eop} !== {1'b0, 1'b1, 8'h00, 5'b0}
        || src_data !== 32'h0 || core_log.size() != 2)
      $display("FAIL midfeed_reset: rdy=%b krst=%b kin=%h kir=%b kl=%b sv=%b d=%h bytes=%0d want 0 1 00 0 0 0 0 2",
               snk_ready, k_reset, k_in, k_in_ready, k_is_last, src_valid, src_data, core_log.size());
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (k_reset !== 1'b0 || snk_ready !== 1'b1)
      $display("FAIL midfeed_release: k_reset=%b snk_ready=%b want 0 1", k_reset, snk_ready);
    else n_pass++;
    out_log.delete();
    w = {32'h61626300};
    send_msg(w, 2'd1, 1'b0);
    wait_done("midfeed_abc");
    n_checks++;
    if (out_log.size() != 16 || out_log[0] !== 32'h18587dc2)
      $display("FAIL midfeed_abc: got n=%0d w0=%h want 16 18587dc2", out_log.size(),
               out_log.size() > 0 ? out_log[0] : 32'h0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_core_backpressure();
    test_empty_sweep();
    test_src_backpressure();
    test_framing();
    test_reset_mid_feed();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached want completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
